src_bridge_ctrl: RTL and testbench
==================================

# src_bridge_ctrl

Source-domain controller for the AHB-to-APB bridge, succeeding the single-outstanding source controller. It sits between the AHB-side slave interface and the source ends of the request/response async FIFOs. It packs requests into the request FIFO and tracks up to MAX_OUTSTANDING reads in flight. It returns registered read responses with error status, and runs a drain/sleep/wake handshake with a bounded drain timeout.

## Interface
Parameters:
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, data width
- MAX_OUTSTANDING, 4, maximum reads accepted but not yet answered (≥1)
- DRAIN_TIMEOUT, 255, cycles allowed in DRAIN before forced sleep (≥1)
- WAKE_CYCLES, 2, cycles spent in WAKE before RUN (≥1)
- Derived: REQ_W = ADDR_WIDTH+DATA_WIDTH+1; RSP_W = DATA_WIDTH+1; OUT_W = $clog2(MAX_OUTSTANDING+1)

Ports (one clock; reset is asynchronous, active-low):
- i_clk_src  in  1  source clock
- i_rstn_src  in  1  asynchronous active-low reset
- i_src_sleep_req  in  1  local sleep request (level)
- sink_sleep_status  in  1  sink side is sleeping/requesting sleep (level)
- rd0_wr1  in  1  request type, 1 = write
- addr  in  ADDR_WIDTH  request address
- wr_data  in  DATA_WIDTH  write data
- valid  in  1  request valid
- ready  out  1  request accepted when valid && ready
- rd_data  out  DATA_WIDTH  read response data
- rd_err  out  1  read response error (packet MSB)
- rd_valid  out  1  one-cycle response strobe
- req_fifo_full  in  1  request FIFO full
- req_fifo_empty  in  1  request FIFO empty
- rsp_fifo_empty  in  1  response FIFO empty
- i_rsp_packet  in  RSP_W  {err, data}, first-word-fall-through
- o_packet  out  REQ_W  {rd0_wr1, addr, wr_data}
- req_fifo_wr_en  out  1  push request
- rsp_fifo_rd_en  out  1  pop response
- o_src_sleep_ack  out  1  sleep acknowledge (level)
- source_sleep_status  out  1  source is in SLEEP
- o_fifo_flush_n  out  1  active-low FIFO pointer flush
- o_drain_timeout  out  1  one-cycle pulse on forced sleep
- o_unexp_rsp  out  1  one-cycle pulse on response with zero outstanding

## Operation
- FSM states: RUN, DRAIN, SLEEP, WAKE. Reset state is RUN.
- RUN
  - ready = !req_fifo_full && (outstanding < MAX_OUTSTANDING). ready is combinational from registers and inputs, independent of valid.
  - req_fifo_wr_en = valid && ready. o_packet = {rd0_wr1, addr, wr_data}, driven combinationally.
  - rsp_fifo_rd_en = !rsp_fifo_empty.
  - Exit to DRAIN when i_src_sleep_req || sink_sleep_status.
- DRAIN
  - ready = 0 and req_fifo_wr_en = 0. Responses keep popping.
  - Drain counter increments each cycle.
  - Exit to SLEEP when req_fifo_empty && rsp_fifo_empty && outstanding == 0.
  - Forced exit to SLEEP when the counter reaches DRAIN_TIMEOUT: pulse o_drain_timeout and clear outstanding. The normal exit condition wins if both hold in the same cycle.
  - If the sleep request drops before the exit condition holds, the controller still completes the drain to SLEEP; there is no abort path.
- SLEEP
  - source_sleep_status = 1 and o_fifo_flush_n = 0. ready = 0 and rsp_fifo_rd_en = 0.
  - o_src_sleep_ack = i_src_sleep_req.
  - Exit to WAKE when !i_src_sleep_req && !sink_sleep_status.
- WAKE
  - o_fifo_flush_n = 1, ready = 0, no pops.
  - Counts WAKE_CYCLES cycles, then moves to RUN.
- Outstanding counter (OUT_W bits)
  - Increments on an accepted read; decrements on a pop.
  - An accepted read and a pop in the same cycle leave it unchanged.
  - A pop with the counter at 0 pulses o_unexp_rsp; the counter stays 0 and never underflows.
  - Writes are posted and are not counted.

## Timing
- Reset values: state RUN, outstanding 0, drain/wake counters 0, rd_valid 0, rd_data 0, rd_err 0, o_drain_timeout 0, o_unexp_rsp 0. o_fifo_flush_n is 1 after reset.
- Request path: zero latency; the push occurs in the same cycle as valid && ready.
- Response path: pop in cycle N; rd_valid, rd_data and rd_err are registered and appear in cycle N+1.
  - rd_data and rd_err hold their value until the next pop.
  - rd_valid is high for exactly one cycle per pop.
- Sleep entry: the request is seen in cycle N; ready drops in N+1 (state register). o_src_sleep_ack is high from the first SLEEP cycle.
- Wake: from the first cycle both requests are low in SLEEP, ready can rise after exactly 1 + WAKE_CYCLES cycles.
- A reset mid-operation immediately returns the block to RUN with all counters cleared, in any state.

## Structure
- Shared package br_pkg holds:
  - state encoding enum (RUN=2'b00, DRAIN=2'b01, SLEEP=2'b11, WAKE=2'b10)
  - packet field offset/width helper functions
- One sub-module is natural: br_outstanding_ctr, a saturating up/down counter with an underflow flag, parametrised by MAX_OUTSTANDING.

## Test plan
- Reset, then 3 reads to addr 0x10/0x14/0x18 with MAX_OUTSTANDING=2 → the third read is stalled (ready=0) until the first response pops; o_packet = {0, 0x10, x} on the first push.
- Response FIFO holds {0, 0xDEADBEEF} → rd_valid one cycle after rsp_fifo_rd_en, rd_data = 0xDEADBEEF, rd_err = 0.
- Same-cycle read accept and pop with outstanding=1 → outstanding stays 1; no o_unexp_rsp.
- i_src_sleep_req with 1 read outstanding → DRAIN until the response pops and both FIFOs are empty; then SLEEP with o_src_sleep_ack=1 and o_fifo_flush_n=0. After the request is released → WAKE for 2 cycles, then RUN with ready=1.
- DRAIN_TIMEOUT=8, response never arrives → o_drain_timeout pulses after 8 DRAIN cycles, the block enters SLEEP, and outstanding=0.
- Pop with outstanding=0 → o_unexp_rsp pulses one cycle; the counter stays 0. Assert reset mid-DRAIN → state RUN and all outputs at reset values.

Source files
------------

// File: rtl/br_pkg.sv
// rtl/br_pkg.sv - shared state encoding and packet layout helpers for the bridge source controller
package br_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DRAIN = 2'b01,
        SLEEP = 2'b11,
        WAKE  = 2'b10
    } br_state_e;

    // Request packet is {rd0_wr1, addr, wr_data}; response packet is {err, data}.
    function automatic int req_w(input int aw, input int dw);
        return aw + dw + 1;
    endfunction

    function automatic int rsp_w(input int dw);
        return dw + 1;
    endfunction

    function automatic int req_addr_lsb(input int dw);
        return dw;
    endfunction

    function automatic int req_type_bit(input int aw, input int dw);
        return aw + dw;
    endfunction

    function automatic int rsp_err_bit(input int dw);
        return dw;
    endfunction

endpackage

// File: rtl/src_bridge_ctrl_if.sv
// rtl/src_bridge_ctrl_if.sv - AHB-side request/response bus of the bridge source controller
interface src_bridge_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  rd0_wr1;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_err;
    logic                  rd_valid;

    modport master (
        output rd0_wr1, addr, wr_data, valid,
        input  ready, rd_data, rd_err, rd_valid
    );

    modport slave (
        input  rd0_wr1, addr, wr_data, valid,
        output ready, rd_data, rd_err, rd_valid
    );
endinterface

// File: rtl/br_outstanding_ctr.sv
// rtl/br_outstanding_ctr.sv - saturating up/down count of reads in flight with underflow flag
module br_outstanding_ctr #(
    parameter int  MAX_OUTSTANDING = 4,
    localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic [OUT_W-1:0] cnt_o,
    output logic             underflow_o
);
    logic [OUT_W-1:0] cnt_q;
    logic [OUT_W-1:0] cnt_d;

    always_comb begin
        cnt_d       = cnt_q;
        underflow_o = dec_i && !inc_i && (cnt_q == '0);
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i) begin
            if (cnt_q != OUT_W'(MAX_OUTSTANDING)) cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/src_bridge_ctrl.sv
// rtl/src_bridge_ctrl.sv - source-domain bridge controller: request packing, read tracking, drain/sleep/wake
module src_bridge_ctrl
    import br_pkg::*;
#(
    parameter int  ADDR_WIDTH      = 32,
    parameter int  DATA_WIDTH      = 32,
    parameter int  MAX_OUTSTANDING = 4,
    parameter int  DRAIN_TIMEOUT   = 255,
    parameter int  WAKE_CYCLES     = 2,
    localparam int REQ_W           = req_w(ADDR_WIDTH, DATA_WIDTH),
    localparam int RSP_W           = rsp_w(DATA_WIDTH),
    localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              i_clk_src,
    input  logic              i_rstn_src,
    input  logic              i_src_sleep_req,
    input  logic              sink_sleep_status,
    src_bridge_ctrl_if.slave  bus,
    input  logic              req_fifo_full,
    input  logic              req_fifo_empty,
    input  logic              rsp_fifo_empty,
    input  logic [RSP_W-1:0]  i_rsp_packet,
    output logic [REQ_W-1:0]  o_packet,
    output logic              req_fifo_wr_en,
    output logic              rsp_fifo_rd_en,
    output logic              o_src_sleep_ack,
    output logic              source_sleep_status,
    output logic              o_fifo_flush_n,
    output logic              o_drain_timeout,
    output logic              o_unexp_rsp
);
    localparam int DRAIN_W  = $clog2(DRAIN_TIMEOUT + 1);
    localparam int WAKE_W   = $clog2(WAKE_CYCLES + 1);
    localparam int ADDR_LSB = req_addr_lsb(DATA_WIDTH);
    localparam int TYPE_BIT = req_type_bit(ADDR_WIDTH, DATA_WIDTH);
    localparam int ERR_BIT  = rsp_err_bit(DATA_WIDTH);

    br_state_e            state_q, state_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [WAKE_W-1:0]    wake_cnt_q, wake_cnt_d;
    logic                 rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                 rd_err_q;
    logic                 drain_to_q;
    logic                 unexp_q;

    logic                 ready_c;
    logic                 pop_c;
    logic                 timeout_c;
    logic                 rd_accept_c;
    logic                 underflow_c;
    logic [OUT_W-1:0]     out_cnt;

    br_outstanding_ctr #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_out_ctr (
        .clk_i       (i_clk_src),
        .rst_ni      (i_rstn_src),
        .inc_i       (rd_accept_c),
        .dec_i       (pop_c),
        .clr_i       (timeout_c),
        .cnt_o       (out_cnt),
        .underflow_o (underflow_c)
    );

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        wake_cnt_d  = wake_cnt_q;
        ready_c     = 1'b0;
        pop_c       = 1'b0;
        timeout_c   = 1'b0;
        case (state_q)
            RUN: begin
                ready_c = !req_fifo_full && (out_cnt < OUT_W'(MAX_OUTSTANDING));
                pop_c   = !rsp_fifo_empty;
                if (i_src_sleep_req || sink_sleep_status) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                pop_c       = !rsp_fifo_empty;
                drain_cnt_d = drain_cnt_q + 1'b1;
                // A clean drain takes precedence over the timeout in the same cycle.
                if (req_fifo_empty && rsp_fifo_empty && (out_cnt == '0)) begin
                    state_d     = SLEEP;
                    drain_cnt_d = '0;
                end else if (drain_cnt_d == DRAIN_W'(DRAIN_TIMEOUT)) begin
                    state_d     = SLEEP;
                    timeout_c   = 1'b1;
                    drain_cnt_d = '0;
                end
            end
            SLEEP: begin
                if (!i_src_sleep_req && !sink_sleep_status) begin
                    state_d    = WAKE;
                    wake_cnt_d = '0;
                end
            end
            WAKE: begin
                if (wake_cnt_q == WAKE_W'(WAKE_CYCLES - 1)) begin
                    state_d    = RUN;
                    wake_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign rd_accept_c = bus.valid && ready_c && !bus.rd0_wr1;

    always_ff @(posedge i_clk_src or negedge i_rstn_src) begin
        if (!i_rstn_src) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
            wake_cnt_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_err_q    <= 1'b0;
            drain_to_q  <= 1'b0;
            unexp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            wake_cnt_q  <= wake_cnt_d;
            rd_valid_q  <= pop_c;
            drain_to_q  <= timeout_c;
            unexp_q     <= underflow_c;
            if (pop_c) begin
                rd_data_q <= i_rsp_packet[DATA_WIDTH-1:0];
                rd_err_q  <= i_rsp_packet[ERR_BIT];
            end
        end
    end

    always_comb begin
        o_packet                             = '0;
        o_packet[DATA_WIDTH-1:0]             = bus.wr_data;
        o_packet[ADDR_LSB +: ADDR_WIDTH]     = bus.addr;
        o_packet[TYPE_BIT]                   = bus.rd0_wr1;
    end

    assign bus.ready           = ready_c;
    assign bus.rd_data         = rd_data_q;
    assign bus.rd_err          = rd_err_q;
    assign bus.rd_valid        = rd_valid_q;
    assign req_fifo_wr_en      = bus.valid && ready_c;
    assign rsp_fifo_rd_en      = pop_c;
    assign source_sleep_status = (state_q == SLEEP);
    assign o_fifo_flush_n      = (state_q != SLEEP);
    assign o_src_sleep_ack     = (state_q == SLEEP) && i_src_sleep_req;
    assign o_drain_timeout     = drain_to_q;
    assign o_unexp_rsp         = unexp_q;

endmodule

// File: tb/tb_src_bridge_ctrl.sv
// tb/tb_src_bridge_ctrl.sv - directed self-checking bench for src_bridge_ctrl
module tb_src_bridge_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sleep_req, sink_sleep, req_full, req_empty, rsp_empty;
    logic [DW:0]      rsp_pkt;
    logic [AW+DW:0]   packet;
    logic [AW+DW:0]   exp_pkt;
    logic wr_en, rd_en, ack, sstat, flush_n, dto, unexp;
    int total = 0;
    int bad = 0;

    src_bridge_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    src_bridge_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(2),
        .DRAIN_TIMEOUT(8), .WAKE_CYCLES(2)
    ) dut (
        .i_clk_src(clk), .i_rstn_src(rst_n), .i_src_sleep_req(sleep_req),
        .sink_sleep_status(sink_sleep), .bus(bus), .req_fifo_full(req_full),
        .req_fifo_empty(req_empty), .rsp_fifo_empty(rsp_empty), .i_rsp_packet(rsp_pkt),
        .o_packet(packet), .req_fifo_wr_en(wr_en), .rsp_fifo_rd_en(rd_en),
        .o_src_sleep_ack(ack), .source_sleep_status(sstat), .o_fifo_flush_n(flush_n),
        .o_drain_timeout(dto), .o_unexp_rsp(unexp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.valid = v; bus.rd0_wr1 = w; bus.addr = a; bus.wr_data = d;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, '0, '0);
        sleep_req = 0; sink_sleep = 0; req_full = 0; req_empty = 1; rsp_empty = 1; rsp_pkt = '0;
        rst_n = 0;
        repeat (3) tick();
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0h exp=1", bus.ready); end
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%0h exp=0", bus.rd_valid); end
        total++; if (bus.rd_data !== 32'h0) begin bad++; $display("FAIL rst_rd_data got=%0h exp=0", bus.rd_data); end
        total++; if (bus.rd_err !== 1'b0) begin bad++; $display("FAIL rst_rd_err got=%0h exp=0", bus.rd_err); end
        total++; if (dto !== 1'b0 || unexp !== 1'b0) begin bad++; $display("FAIL rst_pulses got dto=%0h unexp=%0h exp=0", dto, unexp); end
        total++; if (flush_n !== 1'b1 || sstat !== 1'b0 || ack !== 1'b0) begin bad++; $display("FAIL rst_sleep got flush_n=%0h sstat=%0h ack=%0h exp=1/0/0", flush_n, sstat, ack); end
        total++; if (wr_en !== 1'b0 || rd_en !== 1'b0) begin bad++; $display("FAIL rst_fifo_en got wr=%0h rd=%0h exp=0", wr_en, rd_en); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_read_stall();
        drive(1'b1, 1'b0, 32'h10, 32'hA5A5A5A5);
        exp_pkt = {1'b0, 32'h10, 32'hA5A5A5A5};
        #1;
        total++; if (bus.ready !== 1'b1 || wr_en !== 1'b1) begin bad++; $display("FAIL rd1_push got ready=%0h wr=%0h exp=1", bus.ready, wr_en); end
        total++; if (packet !== exp_pkt) begin bad++; $display("FAIL rd1_packet got=%0h exp=%0h", packet, exp_pkt); end
        tick();
        drive(1'b1, 1'b0, 32'h14, 32'h0); #1;
        total++; if (bus.ready !== 1'b1 || wr_en !== 1'b1) begin bad++; $display("FAIL rd2_push got ready=%0h wr=%0h exp=1", bus.ready, wr_en); end
        tick();
        drive(1'b1, 1'b0, 32'h18, 32'h0); #1;
        total++; if (bus.ready !== 1'b0 || wr_en !== 1'b0) begin bad++; $display("FAIL rd3_stall got ready=%0h wr=%0h exp=0", bus.ready, wr_en); end
        tick();
        rsp_empty = 0; rsp_pkt = {1'b0, 32'hDEADBEEF}; #1;
        total++; if (rd_en !== 1'b1 || bus.ready !== 1'b0) begin bad++; $display("FAIL rsp1_pop got rd_en=%0h ready=%0h exp=1/0", rd_en, bus.ready); end
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rsp1_early got=%0h exp=0", bus.rd_valid); end
        tick();
        rsp_empty = 1; #1;
        total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'hDEADBEEF || bus.rd_err !== 1'b0) begin bad++; $display("FAIL rsp1_data got v=%0h d=%0h e=%0h exp=1/deadbeef/0", bus.rd_valid, bus.rd_data, bus.rd_err); end
        total++; if (bus.ready !== 1'b1 || wr_en !== 1'b1) begin bad++; $display("FAIL rd3_release got ready=%0h wr=%0h exp=1", bus.ready, wr_en); end
        tick();
        drive(1'b0, 1'b0, '0, '0); #1;
        total++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rsp1_hold got v=%0h d=%0h exp=0/deadbeef", bus.rd_valid, bus.rd_data); end
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL out_full got=%0h exp=0", bus.ready); end
    endtask

    task automatic test_same_cycle();
        rsp_empty = 0; rsp_pkt = {1'b1, 32'h12345678};
        tick();
        drive(1'b1, 1'b0, 32'h20, 32'h0);
        rsp_pkt = {1'b0, 32'hCAFEF00D}; #1;
        total++; if (bus.ready !== 1'b1 || wr_en !== 1'b1 || rd_en !== 1'b1) begin bad++; $display("FAIL same_cyc got ready=%0h wr=%0h rd=%0h exp=1", bus.ready, wr_en, rd_en); end
        total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h12345678 || bus.rd_err !== 1'b1) begin bad++; $display("FAIL rsp_err got v=%0h d=%0h e=%0h exp=1/12345678/1", bus.rd_valid, bus.rd_data, bus.rd_err); end
        tick();
        drive(1'b0, 1'b0, '0, '0); rsp_empty = 1; #1;
        total++; if (bus.ready !== 1'b1 || unexp !== 1'b0) begin bad++; $display("FAIL same_cyc_cnt got ready=%0h unexp=%0h exp=1/0", bus.ready, unexp); end
        total++; if (bus.rd_data !== 32'hCAFEF00D) begin bad++; $display("FAIL same_cyc_data got=%0h exp=cafef00d", bus.rd_data); end
        tick();
        drive(1'b1, 1'b0, 32'h24, 32'h0); #1;
        total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL rd4_push got=%0h exp=1", wr_en); end
        tick();
        drive(1'b0, 1'b0, '0, '0); #1;
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL out_two got=%0h exp=0", bus.ready); end
        rsp_empty = 0;
        repeat (2) tick();
        rsp_empty = 1; #1;
        total++; if (unexp !== 1'b0 || bus.ready !== 1'b1) begin bad++; $display("FAIL drain_pops got unexp=%0h ready=%0h exp=0/1", unexp, bus.ready); end
    endtask

    task automatic test_unexp_rsp();
        rsp_empty = 0; rsp_pkt = {1'b0, 32'h11};
        tick();
        rsp_empty = 1; #1;
        total++; if (unexp !== 1'b1 || bus.rd_valid !== 1'b1) begin bad++; $display("FAIL unexp_pulse got unexp=%0h v=%0h exp=1", unexp, bus.rd_valid); end
        tick();
        drive(1'b1, 1'b0, 32'h40, 32'h0); #1;
        total++; if (unexp !== 1'b0 || bus.ready !== 1'b1) begin bad++; $display("FAIL unexp_end got unexp=%0h ready=%0h exp=0/1", unexp, bus.ready); end
        tick(); #1;
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL unexp_cnt1 got=%0h exp=1", bus.ready); end
        tick(); #1;
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL unexp_cnt2 got=%0h exp=0", bus.ready); end
        drive(1'b0, 1'b0, '0, '0);
        rsp_empty = 0;
        repeat (2) tick();
        rsp_empty = 1;
        tick();
    endtask

    task automatic test_sleep_wake();
        drive(1'b1, 1'b0, 32'h30, 32'h0);
        tick();
        drive(1'b0, 1'b0, '0, '0); sleep_req = 1; #1;
        total++; if (bus.ready !== 1'b1 || sstat !== 1'b0) begin bad++; $display("FAIL slp_seen got ready=%0h sstat=%0h exp=1/0", bus.ready, sstat); end
        tick();
        total++; if (bus.ready !== 1'b0 || sstat !== 1'b0 || flush_n !== 1'b1 || ack !== 1'b0) begin bad++; $display("FAIL drain_state got ready=%0h sstat=%0h flush_n=%0h ack=%0h exp=0/0/1/0", bus.ready, sstat, flush_n, ack); end
        tick();
        rsp_empty = 0; rsp_pkt = {1'b0, 32'h55}; #1;
        total++; if (rd_en !== 1'b1) begin bad++; $display("FAIL drain_pop got=%0h exp=1", rd_en); end
        tick();
        rsp_empty = 1; #1;
        total++; if (sstat !== 1'b0 || bus.rd_valid !== 1'b1) begin bad++; $display("FAIL drain_last got sstat=%0h v=%0h exp=0/1", sstat, bus.rd_valid); end
        tick();
        rsp_empty = 0; #1;
        total++; if (sstat !== 1'b1 || flush_n !== 1'b0 || ack !== 1'b1) begin bad++; $display("FAIL sleep_state got sstat=%0h flush_n=%0h ack=%0h exp=1/0/1", sstat, flush_n, ack); end
        total++; if (bus.ready !== 1'b0 || rd_en !== 1'b0 || dto !== 1'b0) begin bad++; $display("FAIL sleep_quiet got ready=%0h rd=%0h dto=%0h exp=0", bus.ready, rd_en, dto); end
        tick();
        rsp_empty = 1; sleep_req = 0; #1;
        total++; if (sstat !== 1'b1 || ack !== 1'b0) begin bad++; $display("FAIL sleep_release got sstat=%0h ack=%0h exp=1/0", sstat, ack); end
        tick();
        total++; if (flush_n !== 1'b1 || sstat !== 1'b0 || bus.ready !== 1'b0) begin bad++; $display("FAIL wake1 got flush_n=%0h sstat=%0h ready=%0h exp=1/0/0", flush_n, sstat, bus.ready); end
        tick();
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL wake2 got=%0h exp=0", bus.ready); end
        tick();
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL wake_run got=%0h exp=1", bus.ready); end
    endtask

    task automatic test_drain_timeout();
        drive(1'b1, 1'b0, 32'h50, 32'h0);
        tick();
        drive(1'b0, 1'b0, '0, '0); sleep_req = 1;
        tick();
        for (int i = 0; i < 8; i++) begin
            total++; if (sstat !== 1'b0 || dto !== 1'b0) begin bad++; $display("FAIL to_drain%0d got sstat=%0h dto=%0h exp=0", i, sstat, dto); end
            tick();
        end
        total++; if (sstat !== 1'b1 || dto !== 1'b1 || ack !== 1'b1) begin bad++; $display("FAIL to_pulse got sstat=%0h dto=%0h ack=%0h exp=1", sstat, dto, ack); end
        tick();
        sleep_req = 0; #1;
        total++; if (dto !== 1'b0) begin bad++; $display("FAIL to_oneshot got=%0h exp=0", dto); end
        repeat (3) tick();
        drive(1'b1, 1'b0, 32'h60, 32'h0); #1;
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL to_clr1 got=%0h exp=1", bus.ready); end
        tick(); #1;
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL to_clr2 got=%0h exp=1", bus.ready); end
        tick(); #1;
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL to_clr3 got=%0h exp=0", bus.ready); end
        drive(1'b0, 1'b0, '0, '0);
        rsp_empty = 0; rsp_pkt = {1'b1, 32'h77};
        repeat (2) tick();
        rsp_empty = 1;
        tick();
    endtask

    task automatic test_reset_mid_drain();
        drive(1'b1, 1'b0, 32'h70, 32'h0);
        tick();
        drive(1'b0, 1'b0, '0, '0); sleep_req = 1;
        tick();
        total++; if (bus.ready !== 1'b0 || bus.rd_data !== 32'h77) begin bad++; $display("FAIL pre_rst got ready=%0h d=%0h exp=0/77", bus.ready, bus.rd_data); end
        tick();
        rst_n = 0; #1;
        total++; if (bus.ready !== 1'b1 || sstat !== 1'b0 || flush_n !== 1'b1) begin bad++; $display("FAIL mid_rst_state got ready=%0h sstat=%0h flush_n=%0h exp=1/0/1", bus.ready, sstat, flush_n); end
        total++; if (bus.rd_data !== 32'h0 || bus.rd_err !== 1'b0 || bus.rd_valid !== 1'b0 || dto !== 1'b0 || unexp !== 1'b0) begin bad++; $display("FAIL mid_rst_out got d=%0h e=%0h v=%0h dto=%0h unexp=%0h exp=0", bus.rd_data, bus.rd_err, bus.rd_valid, dto, unexp); end
        sleep_req = 0;
        tick();
        rst_n = 1;
        tick();
        drive(1'b1, 1'b0, 32'h80, 32'h0); #1;
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL post_rst1 got=%0h exp=1", bus.ready); end
        tick(); #1;
        total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL post_rst2 got=%0h exp=1", bus.ready); end
        tick(); #1;
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL post_rst3 got=%0h exp=0", bus.ready); end
        drive(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        test_reset();
        test_read_stall();
        test_same_cycle();
        test_unexp_rsp();
        test_sleep_wake();
        test_drain_timeout();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
